// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared opcode encodings, flag bit positions and datapath width
//               for the ALU writeback stage and its flag generator.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

  // Datapath width of the upstream CLA-based ALU
  localparam int ALU_WIDTH = 16;

  // ALU opcodes; op[2] doubles as the B-invert control
  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  // Bit positions inside the 4-bit {Z,N,C,V} flag vector
  localparam int FLG_Z = 3;
  localparam int FLG_N = 2;
  localparam int FLG_C = 1;
  localparam int FLG_V = 0;

  // Only the adder opcodes produce a meaningful carry and overflow
  function automatic logic op_is_arith(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_flag_gen.sv
`default_nettype none
// ============================================================================
// Module      : alu_flag_gen
// Description : Combinational {Z,N,C,V} derivation from a raw ALU result.
//               C and V are only passed through for ADD/SUB; logical ops,
//               SLT and undefined opcodes report them as zero.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_flag_gen
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] result_i,
  input  logic             cout_i,
  input  logic             ovf_i,
  input  logic [2:0]       op_i,
  output logic [3:0]       flags_o
);

  // Z/N come straight from the result; C/V gated by the opcode class
  always_comb begin
    flags_o        = '0;
    flags_o[FLG_Z] = (result_i == '0);
    flags_o[FLG_N] = result_i[WIDTH-1];
    if (op_is_arith(op_i)) begin
      flags_o[FLG_C] = cout_i;
      flags_o[FLG_V] = ovf_i;
    end
  end

endmodule : alu_flag_gen
`default_nettype wire

// File: rtl/alu_result_stage.sv
`default_nettype none
// ============================================================================
// Module      : alu_result_stage
// Description : Registered writeback stage behind the 16-bit ALU. Flags are
//               derived on the push path, entries are buffered in a small
//               FIFO and handed to register-file writeback via valid/ready.
//               The architectural status register captures the flags of
//               every retired entry.
//               Optional feature macro: ALU_STICKY_OVF_EN adds clr_sticky and
//               a sticky overflow bit set by any retired V=1 entry.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int WIDTH  = ALU_WIDTH,
  parameter int DEPTH  = 2,
  parameter int DEST_W = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_result,
  input  logic                     in_cout,
  input  logic                     in_overflow,
  input  logic [2:0]               in_op,
  input  logic [DEST_W-1:0]        in_dest,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_result,
  output logic [DEST_W-1:0]        out_dest,
  output logic [3:0]               out_flags,
  output logic [3:0]               status,
  output logic [$clog2(DEPTH):0]   count
`ifdef ALU_STICKY_OVF_EN
  ,
  input  logic                     clr_sticky,
  output logic                     sticky_ovf
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  // FIFO storage (no reset needed: occupancy gates visibility)
  logic [WIDTH-1:0]  res_q  [DEPTH];
  logic [DEST_W-1:0] dest_q [DEPTH];
  logic [3:0]        flg_q  [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;
  logic [3:0]    status_q, status_d;

  logic       push;
  logic       pop;
  logic [3:0] push_flags;

  alu_flag_gen #(
    .WIDTH (WIDTH)
  ) u_flag_gen (
    .result_i (in_result),
    .cout_i   (in_cout),
    .ovf_i    (in_overflow),
    .op_i     (in_op),
    .flags_o  (push_flags)
  );

  // Handshake qualifiers depend only on registered occupancy
  assign in_ready  = (count_q != FULL_COUNT);
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Head entry is presented as zero whenever the FIFO is empty
  assign out_result = out_valid ? res_q[rd_ptr_q]  : '0;
  assign out_dest   = out_valid ? dest_q[rd_ptr_q] : '0;
  assign out_flags  = out_valid ? flg_q[rd_ptr_q]  : '0;
  assign status     = status_q;
  assign count      = count_q;

  // Next-state for pointers, occupancy and status; flush discards the cycle's handshakes
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    status_d = status_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
        status_d = out_flags;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register; reset dominates flush
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      status_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      status_q <= status_d;
    end
  end

  // Write the incoming result and its derived flags into the tail slot
  always_ff @(posedge clk) begin
    if (push && !reset && !flush) begin
      res_q[wr_ptr_q]  <= in_result;
      dest_q[wr_ptr_q] <= in_dest;
      flg_q[wr_ptr_q]  <= push_flags;
    end
  end

`ifdef ALU_STICKY_OVF_EN
  logic sticky_q, sticky_d;

  // A retiring V=1 entry wins over a coincident clear
  always_comb begin
    sticky_d = sticky_q;
    if (!flush && pop && out_flags[FLG_V]) begin
      sticky_d = 1'b1;
    end else if (clr_sticky) begin
      sticky_d = 1'b0;
    end
  end

  // Sticky overflow register
  always_ff @(posedge clk) begin
    if (reset) begin
      sticky_q <= 1'b0;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  assign sticky_ovf = sticky_q;
`endif

endmodule : alu_result_stage
`default_nettype wire

// File: tb/tb_alu_result_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_result_stage
// Description : Self-checking bench for alu_result_stage: queue-based
//               reference model, per-cycle compare, directed scenarios and a
//               randomized phase. Sticky-overflow checks follow
//               ALU_STICKY_OVF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_result_stage;

  localparam int W  = 16;
  localparam int D  = 2;
  localparam int DW = 3;

  logic          clk = 1'b0;
  logic          reset, flush, in_valid, in_ready, in_cout, in_overflow;
  logic [W-1:0]  in_result;
  logic [2:0]    in_op;
  logic [DW-1:0] in_dest;
  logic          out_valid, out_ready;
  logic [W-1:0]  out_result;
  logic [DW-1:0] out_dest;
  logic [3:0]    out_flags, status;
  logic [1:0]    count;
`ifdef ALU_STICKY_OVF_EN
  logic          clr_sticky, sticky_ovf;
`endif

  alu_result_stage #(.WIDTH(W), .DEPTH(D), .DEST_W(DW)) dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_result   (in_result),
    .in_cout     (in_cout),
    .in_overflow (in_overflow),
    .in_op       (in_op),
    .in_dest     (in_dest),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_dest    (out_dest),
    .out_flags   (out_flags),
    .status      (status),
    .count       (count)
`ifdef ALU_STICKY_OVF_EN
    ,
    .clr_sticky  (clr_sticky),
    .sticky_ovf  (sticky_ovf)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [W-1:0]  r;
    logic [DW-1:0] d;
    logic [3:0]    f;
  } ent_t;

  ent_t       m_q[$];
  logic [3:0] m_status = 4'b0;
  logic       m_sticky = 1'b0;

  // Flags {Z,N,C,V}: carry/overflow only meaningful for ADD and SUB
  function automatic logic [3:0] exp_flags(input logic [W-1:0] r, input logic [2:0] op,
                                           input logic c, input logic v);
    logic arith;
    arith = (op == 3'b010) || (op == 3'b110);
    return {(r == 0), r[W-1], arith & c, arith & v};
  endfunction

  always @(posedge clk) begin
    logic do_push, do_pop, clr;
    ent_t e, h;
`ifdef ALU_STICKY_OVF_EN
    clr = clr_sticky;
`else
    clr = 1'b0;
`endif
    if (reset) begin
      m_q.delete();
      m_status = 4'b0;
      m_sticky = 1'b0;
    end else if (flush) begin
      m_q.delete();
      if (clr) m_sticky = 1'b0;
    end else begin
      do_push = in_valid && (m_q.size() < D);
      do_pop  = out_ready && (m_q.size() > 0);
      if (do_pop) begin
        h = m_q.pop_front();
        m_status = h.f;
        if (h.f[0]) m_sticky = 1'b1;
        else if (clr) m_sticky = 1'b0;
      end else if (clr) begin
        m_sticky = 1'b0;
      end
      if (do_push) begin
        e.r = in_result;
        e.d = in_dest;
        e.f = exp_flags(in_result, in_op, in_cout, in_overflow);
        m_q.push_back(e);
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("count",     32'(count),     32'(m_q.size()));
      chk("out_valid", 32'(out_valid), 32'(m_q.size() > 0));
      chk("in_ready",  32'(in_ready),  32'(m_q.size() < D));
      chk("status",    32'(status),    32'(m_status));
      if (m_q.size() > 0) begin
        chk("out_result", 32'(out_result), 32'(m_q[0].r));
        chk("out_dest",   32'(out_dest),   32'(m_q[0].d));
        chk("out_flags",  32'(out_flags),  32'(m_q[0].f));
      end
`ifdef ALU_STICKY_OVF_EN
      chk("sticky_ovf", 32'(sticky_ovf), 32'(m_sticky));
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [W-1:0] r,
                       input logic c, input logic o, input logic [DW-1:0] d);
    in_valid = v; in_op = op; in_result = r; in_cout = c; in_overflow = o; in_dest = d;
  endtask

  // Push one entry while stalled, pin its flags to a literal, then retire it
  task automatic flag_case(input string name, input logic [2:0] op, input logic [W-1:0] r,
                           input logic c, input logic o, input logic [3:0] expf);
    out_ready = 1'b0;
    drive(1'b1, op, r, c, o, 3'd5);
    step();
    in_valid = 1'b0;
    chk({name, "_flags"}, 32'(out_flags), 32'(expf));
    out_ready = 1'b1;
    step();
    chk({name, "_status"}, 32'(status), 32'(expf));
    out_ready = 1'b0;
  endtask

  logic [3:0] saved_status;

  initial begin
    reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 3'b000, '0, 1'b0, 1'b0, '0);
`ifdef ALU_STICKY_OVF_EN
    clr_sticky = 1'b0;
`endif
    step(); step();
    reset = 1'b0;
    chk_en = 1'b1;

    // Reset state
    chk("rst_count",  32'(count),      32'd0);
    chk("rst_valid",  32'(out_valid),  32'd0);
    chk("rst_ready",  32'(in_ready),   32'd1);
    chk("rst_status", 32'(status),     32'd0);
    chk("rst_result", 32'(out_result), 32'd0);
    chk("rst_dest",   32'(out_dest),   32'd0);
    chk("rst_flags",  32'(out_flags),  32'd0);

    // ADD zero result with carry, writeback ready: one-cycle latency
    out_ready = 1'b1;
    drive(1'b1, 3'b010, 16'h0000, 1'b1, 1'b0, 3'd3);
    step();
    in_valid = 1'b0;
    chk("add_valid", 32'(out_valid), 32'd1);
    chk("add_flags", 32'(out_flags), 32'b1010);
    chk("add_dest",  32'(out_dest),  32'd3);
    step();
    chk("add_status", 32'(status), 32'b1010);
    chk("add_count",  32'(count),  32'd0);

    flag_case("sub",  3'b110, 16'h8000, 1'b0, 1'b1, 4'b0101);
    flag_case("or",   3'b001, 16'h8000, 1'b1, 1'b1, 4'b0100);
    flag_case("and",  3'b000, 16'h0000, 1'b1, 1'b1, 4'b1000);
    flag_case("slt",  3'b111, 16'h0001, 1'b1, 1'b1, 4'b0000);
    flag_case("undef",3'b011, 16'h7fff, 1'b1, 1'b1, 4'b0000);
    flag_case("addcv",3'b010, 16'hffff, 1'b1, 1'b1, 4'b0111);

    // Backpressure: A, B accepted, C refused
    out_ready = 1'b0;
    drive(1'b1, 3'b010, 16'h00aa, 1'b0, 1'b0, 3'd1); step();
    drive(1'b1, 3'b010, 16'h00bb, 1'b0, 1'b0, 3'd2); step();
    chk("full_ready", 32'(in_ready), 32'd0);
    drive(1'b1, 3'b010, 16'h00cc, 1'b0, 1'b0, 3'd4); step();
    chk("full_count", 32'(count), 32'd2);
    in_valid = 1'b0; out_ready = 1'b1;
    chk("order_A", 32'(out_result), 32'h00aa);
    step();
    chk("order_B", 32'(out_result), 32'h00bb);
    step();
    chk("drain_count", 32'(count), 32'd0);

    // Steady push+pop at occupancy 1
    out_ready = 1'b0;
    drive(1'b1, 3'b110, 16'h1000, 1'b1, 1'b0, 3'd0); step();
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 3'b110, 16'(16'h1001 + i), 1'b1, 1'b0, 3'(i));
      step();
      chk("stream_count", 32'(count), 32'd1);
    end
    in_valid = 1'b0;
    step();

    // Flush with full FIFO and a push/pop pending
    out_ready = 1'b0;
    drive(1'b1, 3'b001, 16'h8001, 1'b0, 1'b0, 3'd6); step();
    drive(1'b1, 3'b001, 16'h8002, 1'b0, 1'b0, 3'd7); step();
    saved_status = m_status;
    flush = 1'b1; out_ready = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    chk("flush_count",  32'(count),     32'd0);
    chk("flush_valid",  32'(out_valid), 32'd0);
    chk("flush_status", 32'(status),    32'(saved_status));

    // Reset mid-stream
    drive(1'b1, 3'b110, 16'h8000, 1'b1, 1'b1, 3'd2); step();
    drive(1'b1, 3'b010, 16'h0040, 1'b0, 1'b0, 3'd3);
    out_ready = 1'b1; step();
    reset = 1'b1;
    step();
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    chk("mrst_count",  32'(count),      32'd0);
    chk("mrst_valid",  32'(out_valid),  32'd0);
    chk("mrst_status", 32'(status),     32'd0);
    chk("mrst_result", 32'(out_result), 32'd0);
    chk("mrst_flags",  32'(out_flags),  32'd0);

`ifdef ALU_STICKY_OVF_EN
    drive(1'b1, 3'b110, 16'h0001, 1'b0, 1'b1, 3'd1); step();
    out_ready = 1'b1;
    drive(1'b1, 3'b010, 16'h0002, 1'b0, 1'b0, 3'd2); step();
    in_valid = 1'b0;
    chk("sticky_set", 32'(sticky_ovf), 32'd1);
    step();
    chk("sticky_hold", 32'(sticky_ovf), 32'd1);
    clr_sticky = 1'b1; step(); clr_sticky = 1'b0;
    chk("sticky_clr", 32'(sticky_ovf), 32'd0);
    out_ready = 1'b0;
    drive(1'b1, 3'b110, 16'h0003, 1'b0, 1'b1, 3'd3); step();
    in_valid = 1'b0; out_ready = 1'b1; clr_sticky = 1'b1;
    step();
    clr_sticky = 1'b0; out_ready = 1'b0;
    chk("sticky_setwins", 32'(sticky_ovf), 32'd1);
`endif

    // Randomized phase, checked by the model every cycle
    for (int n = 0; n < 4000; n++) begin
      logic [W-1:0] r;
      case ($urandom_range(0, 3))
        0:       r = 16'h0000;
        1:       r = 16'h8000;
        2:       r = 16'hffff;
        default: r = 16'($urandom);
      endcase
      drive(($urandom_range(0, 3) != 0), 3'($urandom), r, 1'($urandom), 1'($urandom), 3'($urandom));
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 49) == 0);
      reset     = ($urandom_range(0, 199) == 0);
`ifdef ALU_STICKY_OVF_EN
      clr_sticky = ($urandom_range(0, 9) == 0);
`endif
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_alu_result_stage
`default_nettype wire

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- Registered writeback stage directly downstream of the 16-bit ALU built from four-bit CLA slices.
- Captures the ALU result, carry-out, overflow and opcode, then derives condition flags (Z, N, C, V).
- Buffers results in a small FIFO and presents them to register-file writeback with a valid/ready handshake.
- Holds the architectural status register, updated on each retire.

Parameters:
- WIDTH, 16, datapath width; must match the ALU result width.
- DEPTH, 2, FIFO entries; power of two, minimum 2.
- DEST_W, 3, destination register index width.

Ports:
- clk  in  1  single clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  synchronous discard of all buffered entries.
- in_valid  in  1  ALU result presented.
- in_ready  out  1  stage can accept.
- in_result  in  WIDTH  ALU result.
- in_cout  in  1  ALU carry-out of MSB slice.
- in_overflow  in  1  ALU overflow detect.
- in_op  in  3  ALU opcode, op[2] = binv.
- in_dest  in  DEST_W  destination register.
- out_valid  out  1  head entry valid.
- out_ready  in  1  writeback consumes head.
- out_result  out  WIDTH  head result.
- out_dest  out  DEST_W  head destination.
- out_flags  out  4  head flags {Z,N,C,V}.
- status  out  4  flags of the last retired entry.
- count  out  clog2(DEPTH)+1  occupancy.

Behaviour:
- Reset (sync, active-high, clk edge): count=0, out_valid=0, in_ready=1, status=0, out_result/out_dest/out_flags=0. Reset mid-transfer discards all entries; no handshake completes in that cycle.
- Push: in_valid && in_ready at the edge. Pop: out_valid && out_ready at the edge.
- Latency: an entry pushed into an empty FIFO shows out_valid=1 the next cycle. No combinational path from in_* to out_*.
- in_ready = (count != DEPTH), driven from registered count only. It does not depend on out_ready.
- Push and pop in the same cycle with 0 < count < DEPTH: count is unchanged, order is preserved.
- When full, in_ready=0, so no push occurs even if a pop happens in that cycle.
- Read/write pointers wrap modulo DEPTH.
- Outputs are held stable while out_valid && !out_ready.
- Flag derivation at push time, combinational from in_*:
  - Z = (in_result == 0).
  - N = in_result[WIDTH-1].
  - C = in_cout when in_op is ADD(010) or SUB(110), else 0.
  - V = in_overflow when in_op is ADD or SUB, else 0.
  - AND(000), OR(001) and SLT(111) force C=V=0.
  - Undefined opcodes: C=V=0, entry still buffered.
- status loads out_flags on every pop and is otherwise held.
- flush: count=0 and out_valid=0 next cycle; status is not modified. A push or pop in the same cycle as flush is discarded. reset has priority over flush.

Optional Feature:
- Macro ALU_STICKY_OVF_EN.
- When defined, adds input clr_sticky (1) and output sticky_ovf (1).
  - sticky_ovf sets on any pop whose V=1, and clears on clr_sticky or reset.
  - If clr_sticky and a V=1 pop occur in the same cycle, sticky_ovf ends at 1 (set wins).
- When undefined, neither port nor register exists; all other behaviour is identical.

Decomposition:
- Package alu_pkg holds:
  - opcode localparams OP_AND=000, OP_OR=001, OP_ADD=010, OP_SUB=110, OP_SLT=111;
  - flag bit indices FLG_Z=3, FLG_N=2, FLG_C=1, FLG_V=0;
  - the default WIDTH.
- One sub-module, alu_flag_gen: combinational flag derivation, instantiated once on the push path.
- FIFO storage and control stay in alu_result_stage.

Test Plan:
- Reset, then push ADD result=0x0000, cout=1, ovf=0, with out_ready=1 -> next cycle out_valid=1, out_flags=1010; after the pop, status=1010.
- SUB result=0x8000, ovf=1, cout=0 -> flags=0101. OR result=0x8000 with cout=1, ovf=1 -> flags=0100.
- Hold out_ready=0 and push 3 entries (A,B,C) -> in_ready drops after 2 and C is not accepted (count=2). Release -> A then B retire in order.
- count=1, push and pop in the same cycle over 10 cycles -> count stays 1, every value retires once, in order.
- Assert flush with count=2 and push asserted -> next cycle count=0, out_valid=0, status unchanged. Assert reset mid-stream -> all outputs zero next cycle.
- With ALU_STICKY_OVF_EN: retire a V=1 entry, then a V=0 entry -> sticky_ovf stays 1. clr_sticky coincident with a V=1 pop -> sticky_ovf=1.
